jelly_rtos_wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single slave register port of the jelly_rtos core between NUM requesters (e.g. several CPU cores plus a debug bridge).
- One transaction in flight at a time; the grant is held until the slave acks, so RTOS service-call register sequences are never interleaved mid-access.
- Sits directly in front of the RTOS s_wb_* port.

---
 rtl/jelly_rtos_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_jelly_rtos_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_rtos_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the jelly_rtos register port among NUM masters.
// Latency: 1 clk arbitration (IDLE->BUSY), then the master path is combinational until ack.
// Backpressure: grant is held until ack or stb drop; optional JELLY_RTOS_WB_ARBITER_TIMEOUT_EN aborts stalled accesses.
module jelly_rtos_wb_arbiter #(
    parameter int NUM          = 4,
    parameter int WB_ADR_WIDTH = 16,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int TIMEOUT      = 255,
    parameter int GRANT_WIDTH  = $clog2(NUM)
) (
    input  logic                                      reset,
    input  logic                                      clk,

    input  logic [NUM-1:0][WB_ADR_WIDTH-1:0]          s_wb_adr_i,
    input  logic [NUM-1:0][WB_DAT_WIDTH-1:0]          s_wb_dat_i,
    output logic [NUM-1:0][WB_DAT_WIDTH-1:0]          s_wb_dat_o,
    input  logic [NUM-1:0]                            s_wb_we_i,
    input  logic [NUM-1:0][WB_SEL_WIDTH-1:0]          s_wb_sel_i,
    input  logic [NUM-1:0]                            s_wb_stb_i,
    output logic [NUM-1:0]                            s_wb_ack_o,

    output logic [WB_ADR_WIDTH-1:0]                   m_wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0]                   m_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]                   m_wb_dat_i,
    output logic                                      m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]                   m_wb_sel_o,
    output logic                                      m_wb_stb_o,
    input  logic                                      m_wb_ack_i,

    output logic                                      grant_valid,
    output logic [GRANT_WIDTH-1:0]                    grant_index,
    output logic                                      timeout_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [GRANT_WIDTH-1:0] grant_next;
    logic [GRANT_WIDTH-1:0] last_grant;
    logic [GRANT_WIDTH-1:0] last_grant_next;
    logic                   pick_found;
    logic [GRANT_WIDTH-1:0] pick_index;
    logic [GRANT_WIDTH-1:0] cand;
    logic                   busy;
    logic [GRANT_WIDTH-1:0] mux_index;
    logic                   timeout_hit;

    assign busy        = (state == ST_BUSY);
    assign grant_valid = busy;

    // Round-robin pick: first requester after last_grant, wrapping at NUM-1.
    always_comb begin
        pick_found = 1'b0;
        pick_index = '0;
        cand       = last_grant;
        for (int i = 0; i < NUM; i++) begin
            cand = (cand == GRANT_WIDTH'(NUM - 1)) ? '0 : cand + GRANT_WIDTH'(1);
            if (!pick_found && s_wb_stb_i[cand]) begin
                pick_found = 1'b1;
                pick_index = cand;
            end
        end
    end

    // Next-state: grant in IDLE, release in BUSY on ack, timeout or abandoned strobe.
    always_comb begin
        state_next      = state;
        grant_next      = grant_index;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_BUSY;
                    grant_next = pick_index;
                end
            end
            ST_BUSY: begin
                if (m_wb_ack_i || timeout_hit) begin
                    state_next      = ST_IDLE;
                    last_grant_next = grant_index;
                end else if (!s_wb_stb_i[grant_index]) begin
                    // master gave up: release without moving the round-robin pointer
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; last_grant resets to NUM-1 so master 0 has first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant_index <= '0;
            last_grant  <= GRANT_WIDTH'(NUM - 1);
        end else begin
            state       <= state_next;
            grant_index <= grant_next;
            last_grant  <= last_grant_next;
        end
    end

    // Master-side mux follows the grant while BUSY, master 0 otherwise.
    assign mux_index  = busy ? grant_index : '0;
    assign m_wb_adr_o = s_wb_adr_i[mux_index];
    assign m_wb_dat_o = s_wb_dat_i[mux_index];
    assign m_wb_we_o  = s_wb_we_i[mux_index];
    assign m_wb_sel_o = s_wb_sel_i[mux_index];
    assign m_wb_stb_o = busy & s_wb_stb_i[grant_index];

    // Return path: only the granted master sees ack/data; a timeout acks with zero data.
    always_comb begin
        s_wb_ack_o = '0;
        s_wb_dat_o = '0;
        if (busy) begin
            s_wb_ack_o[grant_index] = m_wb_ack_i | timeout_hit;
            s_wb_dat_o[grant_index] = timeout_hit ? '0 : m_wb_dat_i;
        end
    end

`ifdef JELLY_RTOS_WB_ARBITER_TIMEOUT_EN
    localparam int TO_WIDTH = 16;
    logic [TO_WIDTH-1:0] to_cnt;

    // Count unacked BUSY cycles; held at zero while idle so each grant starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!busy) begin
            to_cnt <= '0;
        end else if (!m_wb_ack_i) begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
        end
    end

    // Abort fires in the TIMEOUT-th BUSY cycle without an ack.
    assign timeout_hit = busy && !m_wb_ack_i && (to_cnt == TO_WIDTH'(TIMEOUT - 1));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jelly_rtos_wb_arbiter.sv
// Directed bench for jelly_rtos_wb_arbiter (NUM=4, TIMEOUT=8).
// Inputs change 1ns after posedge or at negedge; outputs are sampled at negedge.
// Expected values are hand-derived constants and small per-master tables.
module tb_jelly_rtos_wb_arbiter;

    localparam int NUM = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int GW  = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM-1:0][AW-1:0]    s_adr;
    logic [NUM-1:0][DW-1:0]    s_dat_w;
    logic [NUM-1:0][DW-1:0]    s_dat_r;
    logic [NUM-1:0]            s_we;
    logic [NUM-1:0][SW-1:0]    s_sel;
    logic [NUM-1:0]            s_stb;
    logic [NUM-1:0]            s_ack;
    logic [AW-1:0]             m_adr;
    logic [DW-1:0]             m_dat_w;
    logic [DW-1:0]             m_dat_r;
    logic                      m_we;
    logic [SW-1:0]             m_sel;
    logic                      m_stb;
    logic                      m_ack;
    logic                      grant_valid;
    logic [GW-1:0]             grant_index;
    logic                      timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_adr [NUM];
    logic [SW-1:0] exp_sel [NUM];

    always #5 clk = ~clk;

    jelly_rtos_wb_arbiter #(
        .NUM          (NUM),
        .WB_ADR_WIDTH (AW),
        .WB_DAT_WIDTH (DW),
        .TIMEOUT      (8)
    ) dut (
        .reset       (reset),
        .clk         (clk),
        .s_wb_adr_i  (s_adr),
        .s_wb_dat_i  (s_dat_w),
        .s_wb_dat_o  (s_dat_r),
        .s_wb_we_i   (s_we),
        .s_wb_sel_i  (s_sel),
        .s_wb_stb_i  (s_stb),
        .s_wb_ack_o  (s_ack),
        .m_wb_adr_o  (m_adr),
        .m_wb_dat_o  (m_dat_w),
        .m_wb_dat_i  (m_dat_r),
        .m_wb_we_o   (m_we),
        .m_wb_sel_o  (m_sel),
        .m_wb_stb_o  (m_stb),
        .m_wb_ack_i  (m_ack),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        s_stb = '0;
        m_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Wait for the grant of master m (expected 1 idle cycle first), optionally
    // stall dly cycles, ack with tagged data, then optionally drop m's strobe.
    task automatic serve(input int m, input int dly, input bit drop, input string tag);
        int  k;
        bit  seen;
        logic [NUM-1:0][DW-1:0] exp_dat;
        seen = 1'b0;
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_stb) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_grant_seen"}, seen, 1'b1);
        if (!seen) return;
        chk({tag, "_latency"}, k, 1);
        chk({tag, "_grant_index"}, grant_index, m);
        chk({tag, "_grant_valid"}, grant_valid, 1'b1);
        chk({tag, "_m_adr"}, m_adr, exp_adr[m]);
        chk({tag, "_m_sel"}, m_sel, exp_sel[m]);
        chk({tag, "_m_we"}, m_we, m % 2);
        chk({tag, "_ack_before"}, s_ack, '0);
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk({tag, "_ack_stall"}, s_ack, '0);
            chk({tag, "_stb_stall"}, m_stb, 1'b1);
        end
        m_dat_r = 32'hD000_0000 | m;
        m_ack   = 1'b1;
        #1;
        chk({tag, "_ack_onehot"}, s_ack, 4'b0001 << m);
        exp_dat    = '0;
        exp_dat[m] = 32'hD000_0000 | m;
        chk({tag, "_rdata"}, s_dat_r, exp_dat);
        @(posedge clk); #1;
        m_ack = 1'b0;
        if (drop) s_stb[m] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_adr[0] = 16'h0100; exp_adr[1] = 16'h0200; exp_adr[2] = 16'h0010; exp_adr[3] = 16'h0300;
        exp_sel[0] = 4'h1;     exp_sel[1] = 4'h3;     exp_sel[2] = 4'hF;     exp_sel[3] = 4'hC;
        for (int i = 0; i < NUM; i++) begin
            s_adr[i]   = exp_adr[i];
            s_sel[i]   = exp_sel[i];
            s_dat_w[i] = 32'hA000_0000 | i;
        end
        s_we    = 4'b1010;
        s_stb   = '0;
        m_dat_r = '0;
        m_ack   = 1'b0;
        reset   = 1'b1;

        // reset values
        @(negedge clk);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_grant_index", grant_index, '0);
        chk("rst_m_stb", m_stb, 1'b0);
        chk("rst_s_ack", s_ack, '0);
        chk("rst_s_dat", s_dat_r, '0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single master 2 read of 0x0010, RTOS acks 2 clk later
        @(posedge clk); #1;
        s_stb = 4'b0100;
        serve(2, 2, 1'b1, "t1");
        @(negedge clk);
        chk("t1_release_valid", grant_valid, 1'b0);
        chk("t1_release_ack", s_ack, '0);

        // masters 0 and 1 together from reset: 0 then 1
        do_reset();
        s_stb = 4'b0011;
        serve(0, 0, 1'b1, "t2a");
        serve(1, 0, 1'b1, "t2b");

        // all four masters continuously: 0,1,2,3,0,1,2,3
        do_reset();
        s_stb = 4'b1111;
        for (int t = 0; t < 8; t++) serve(t % NUM, 0, 1'b0, "t3");
        s_stb = '0;

        // master 1 abandons; pointer must stay at reset value (3)
        do_reset();
        s_stb = 4'b0010;
        @(negedge clk);
        chk("t4_idle_stb", m_stb, 1'b0);
        @(negedge clk);
        chk("t4_grant_index", grant_index, 1);
        chk("t4_m_stb", m_stb, 1'b1);
        s_stb = '0;
        #1;
        chk("t4_drop_m_stb", m_stb, 1'b0);
        chk("t4_drop_ack", s_ack, '0);
        @(negedge clk);
        chk("t4_idle_valid", grant_valid, 1'b0);
        chk("t4_idle_ack", s_ack, '0);
        @(posedge clk); #1;
        s_stb = 4'b0110;
        serve(1, 0, 1'b1, "t4b");
        serve(2, 0, 1'b1, "t4c");

        // reset while busy, with ack presented during reset
        do_reset();
        s_stb = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_valid", grant_valid, 1'b1);
        chk("t5_busy_index", grant_index, 2);
        reset   = 1'b1;
        m_dat_r = 32'h1234_5678;
        m_ack   = 1'b1;
        #1;
        chk("t5_rst_valid", grant_valid, 1'b0);
        chk("t5_rst_index", grant_index, '0);
        chk("t5_rst_m_stb", m_stb, 1'b0);
        chk("t5_rst_ack", s_ack, '0);
        chk("t5_rst_dat", s_dat_r, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ack = 1'b0;
        s_stb = 4'b1000;
        serve(3, 1, 1'b1, "t5b");

        // stalled slave: master 0 never acked by the RTOS, master 1 waiting
        do_reset();
        s_stb   = 4'b0011;
        m_dat_r = 32'hBAD0_BAD0;
        @(negedge clk);
`ifdef JELLY_RTOS_WB_ARBITER_TIMEOUT_EN
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n < 8) begin
                chk("t6_ack_wait", s_ack, '0);
            end else begin
                chk("t6_to_ack", s_ack, 4'b0001);
                chk("t6_to_dat", s_dat_r, '0);
            end
        end
        @(posedge clk); #1;
        s_stb[0] = 1'b0;
        chk("t6_err_set", timeout_err, 1'b1);
        serve(1, 0, 1'b1, "t6b");
        chk("t6_err_sticky", timeout_err, 1'b1);
`else
        repeat (20) @(negedge clk);
        chk("t6_still_valid", grant_valid, 1'b1);
        chk("t6_still_index", grant_index, 0);
        chk("t6_no_ack", s_ack, '0);
        chk("t6_no_err", timeout_err, 1'b0);
        m_dat_r = 32'h0000_00A5;
        m_ack   = 1'b1;
        #1;
        chk("t6_late_ack", s_ack, 4'b0001);
        @(posedge clk); #1;
        m_ack    = 1'b0;
        s_stb[0] = 1'b0;
        serve(1, 0, 1'b1, "t6b");
        chk("t6_err_zero", timeout_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
